// File: rtl/mem_init_loader.sv
// Streaming loader for the instruction and data memories of a riscv core.
// A session is a sequence of segments: a header word, then 2N payload words
// written two at a time. The core is held in reset until every segment has
// been written and a short settling window has passed.
module mem_init_loader #(
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        inst_load_en,
  output logic [8:0]  InstExMemAddress,
  output logic [31:0] InstExMemData1,
  output logic [31:0] InstExMemData2,
  output logic        data_load_en,
  output logic [8:0]  DataExMemAddress,
  output logic [31:0] DataExMemData1,
  output logic [31:0] DataExMemData2,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle, StHeader, StFirst, StSecond, StWrite, StRelease, StDone, StError
  } state_e;

  // Release counter only needs to hold RELEASE_CYCLES-1.
  localparam int unsigned CntW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [CntW-1:0] RelLoad =
    CntW'((RELEASE_CYCLES > 0) ? RELEASE_CYCLES - 1 : 0);

  // Status flags packed as {s_ready, busy, done, error, core_reset}.
  function automatic logic [4:0] flags_of(state_e s);
    logic [4:0] f;
    case (s)
      StIdle:                     f = 5'b00001;
      StHeader, StFirst, StSecond: f = 5'b11001;
      StWrite, StRelease:         f = 5'b01001;
      StDone:                     f = 5'b00100;
      StError:                    f = 5'b00011;
      default:                    f = 5'b00001;
    endcase
    return f;
  endfunction

  state_e          r_state;
  logic [4:0]      r_flags;
  logic            r_target;
  logic            r_last;
  logic [8:0]      r_addr;
  logic [7:0]      r_cnt;
  logic [31:0]     r_data1;
  logic [CntW-1:0] r_rel_cnt;

  logic            r_inst_en;
  logic [8:0]      r_inst_addr;
  logic [31:0]     r_inst_d1;
  logic [31:0]     r_inst_d2;
  logic            r_data_en;
  logic [8:0]      r_data_addr;
  logic [31:0]     r_data_d1;
  logic [31:0]     r_data_d2;

  logic            w_xfer;
  logic [8:0]      w_hdr_addr;
  logic [7:0]      w_hdr_cnt;
  logic [9:0]      w_hdr_end;
  logic            w_hdr_over;
  logic            w_unused_hdr;

  assign w_xfer     = s_valid & r_flags[4];
  assign w_hdr_addr = s_data[16:8];
  assign w_hdr_cnt  = s_data[7:0];
  // 10-bit sum so a segment ending exactly at 512 is distinguishable from overflow.
  assign w_hdr_end  = {1'b0, w_hdr_addr} + {1'b0, w_hdr_cnt, 1'b0};
  assign w_hdr_over = (w_hdr_end > 10'd512);
  assign w_unused_hdr = ^s_data[29:17];

  assign {s_ready, busy, done, error, core_reset} = r_flags;
  assign inst_load_en     = r_inst_en;
  assign InstExMemAddress = r_inst_addr;
  assign InstExMemData1   = r_inst_d1;
  assign InstExMemData2   = r_inst_d2;
  assign data_load_en     = r_data_en;
  assign DataExMemAddress = r_data_addr;
  assign DataExMemData1   = r_data_d1;
  assign DataExMemData2   = r_data_d2;

  // Session FSM; status flags and memory buses are registered with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_flags     <= flags_of(StIdle);
      r_target    <= 1'b0;
      r_last      <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_data1     <= '0;
      r_rel_cnt   <= '0;
      r_inst_en   <= 1'b0;
      r_inst_addr <= '0;
      r_inst_d1   <= '0;
      r_inst_d2   <= '0;
      r_data_en   <= 1'b0;
      r_data_addr <= '0;
      r_data_d1   <= '0;
      r_data_d2   <= '0;
    end else begin
      // Strobes live for the single WRITE cycle only.
      r_inst_en <= 1'b0;
      r_data_en <= 1'b0;
      unique case (r_state)
        StIdle, StDone, StError: begin
          if (start) begin
            r_state <= StHeader;
            r_flags <= flags_of(StHeader);
          end
        end
        StHeader: begin
          if (w_xfer) begin
            r_target <= s_data[31];
            r_last   <= s_data[30];
            r_addr   <= w_hdr_addr;
            r_cnt    <= w_hdr_cnt;
            if (w_hdr_over) begin
              r_state <= StError;
              r_flags <= flags_of(StError);
            end else if (w_hdr_cnt == 8'd0) begin
              // Empty segment: either finish or wait for the next header.
              if (s_data[30]) begin
                r_state   <= StRelease;
                r_flags   <= flags_of(StRelease);
                r_rel_cnt <= RelLoad;
              end
            end else begin
              r_state <= StFirst;
              r_flags <= flags_of(StFirst);
            end
          end
        end
        StFirst: begin
          if (w_xfer) begin
            r_data1 <= s_data;
            r_state <= StSecond;
            r_flags <= flags_of(StSecond);
          end
        end
        StSecond: begin
          if (w_xfer) begin
            // Load the selected bus now so it is valid alongside the strobe.
            if (r_target) begin
              r_data_en   <= 1'b1;
              r_data_addr <= r_addr;
              r_data_d1   <= r_data1;
              r_data_d2   <= s_data;
            end else begin
              r_inst_en   <= 1'b1;
              r_inst_addr <= r_addr;
              r_inst_d1   <= r_data1;
              r_inst_d2   <= s_data;
            end
            r_state <= StWrite;
            r_flags <= flags_of(StWrite);
          end
        end
        StWrite: begin
          r_addr <= r_addr + 9'd2;
          r_cnt  <= r_cnt - 8'd1;
          if (r_cnt != 8'd1) begin
            r_state <= StFirst;
            r_flags <= flags_of(StFirst);
          end else if (r_last) begin
            r_state   <= StRelease;
            r_flags   <= flags_of(StRelease);
            r_rel_cnt <= RelLoad;
          end else begin
            r_state <= StHeader;
            r_flags <= flags_of(StHeader);
          end
        end
        StRelease: begin
          if (r_rel_cnt == '0) begin
            r_state <= StDone;
            r_flags <= flags_of(StDone);
          end else begin
            r_rel_cnt <= r_rel_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_flags <= flags_of(StIdle);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_init_loader.sv
// Directed and randomized sessions against a stream-parsing reference model.
module tb_mem_init_loader;

  localparam int RC = 2;

  typedef struct packed {
    logic        tgt;
    logic [8:0]  addr;
    logic [31:0] d1;
    logic [31:0] d2;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        inst_load_en;
  logic [8:0]  InstExMemAddress;
  logic [31:0] InstExMemData1;
  logic [31:0] InstExMemData2;
  logic        data_load_en;
  logic [8:0]  DataExMemAddress;
  logic [31:0] DataExMemData1;
  logic [31:0] DataExMemData2;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  mem_init_loader #(.RELEASE_CYCLES(RC)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .inst_load_en     (inst_load_en),
    .InstExMemAddress (InstExMemAddress),
    .InstExMemData1   (InstExMemData1),
    .InstExMemData2   (InstExMemData2),
    .data_load_en     (data_load_en),
    .DataExMemAddress (DataExMemAddress),
    .DataExMemData1   (DataExMemData1),
    .DataExMemData2   (DataExMemData2),
    .core_reset       (core_reset),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- monitor ----------------
  wr_t         got_q[$];
  int          hold_bad = 0;
  int          cross_bad = 0;
  int          lat_bad = 0;
  int          inv_bad = 0;
  logic        prev_rst = 1'b1;
  logic        prev_xfer = 1'b0;
  logic [72:0] prev_inst = '0;
  logic [72:0] prev_data = '0;

  // Records writes and flags bus-hold, cross-strobe, latency and core_reset violations.
  always @(negedge clk) begin
    if (prev_rst !== 1'b1) begin
      if (inst_load_en !== 1'b1 &&
          {InstExMemAddress, InstExMemData1, InstExMemData2} !== prev_inst)
        hold_bad <= hold_bad + 1;
      if (data_load_en !== 1'b1 &&
          {DataExMemAddress, DataExMemData1, DataExMemData2} !== prev_data)
        hold_bad <= hold_bad + 1;
    end
    if (inst_load_en === 1'b1 && data_load_en === 1'b1) cross_bad <= cross_bad + 1;
    if ((inst_load_en === 1'b1 || data_load_en === 1'b1) && prev_xfer !== 1'b1)
      lat_bad <= lat_bad + 1;
    if (reset === 1'b0 && prev_rst === 1'b0 && core_reset !== ~done) inv_bad <= inv_bad + 1;
    if (inst_load_en === 1'b1)
      got_q.push_back(wr_t'({1'b0, InstExMemAddress, InstExMemData1, InstExMemData2}));
    if (data_load_en === 1'b1)
      got_q.push_back(wr_t'({1'b1, DataExMemAddress, DataExMemData1, DataExMemData2}));
    prev_inst <= {InstExMemAddress, InstExMemData1, InstExMemData2};
    prev_data <= {DataExMemAddress, DataExMemData1, DataExMemData2};
    prev_xfer <= s_valid & s_ready;
    prev_rst  <= reset;
  end

  // ---------------- reference model ----------------
  logic [31:0] stream[$];
  wr_t         exp_q[$];
  bit          m_err;
  bit          m_pair;
  int          m_used;

  // Parses the stream as headers + payload; yields expected writes and outcome.
  function automatic void build_model();
    int i;
    int a;
    int n;
    logic [31:0] h;
    exp_q.delete();
    m_err  = 1'b0;
    m_pair = 1'b0;
    i = 0;
    for (int seg = 0; seg < 16; seg++) begin
      h = stream[i];
      i++;
      a = int'(h[16:8]);
      n = int'(h[7:0]);
      if (a + 2 * n > 512) begin
        m_err = 1'b1;
        break;
      end
      for (int k = 0; k < n; k++)
        exp_q.push_back(wr_t'({h[31], 9'(a + 2 * k), stream[i + 2 * k], stream[i + 2 * k + 1]}));
      i += 2 * n;
      m_pair = (n != 0);
      if (h[30]) break;
    end
    m_used = i;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // mode 0: no stalls, 1: random stalls (with ignored start pulses), 2: alternate valid.
  task automatic send(input logic [31:0] w, input int mode);
    int stall;
    int g;
    stall = (mode == 1) ? int'($urandom_range(0, 2)) : ((mode == 2) ? 1 : 0);
    s_valid = 1'b0;
    s_data  = $urandom;
    for (int j = 0; j < stall; j++) begin
      if (j == 0 && mode == 1 && $urandom_range(0, 3) == 0) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    s_data  = w;
    s_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (s_ready !== 1'b1 && g < 50) begin
      g++;
      @(negedge clk);
    end
    check("accept_timeout", {73'd0, s_ready}, 74'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic run_session(input string tag, input int mode);
    int got_base;
    int hb, cb, lb, ib;
    int cnt;
    int nchk;
    build_model();
    got_base = got_q.size();
    hb = hold_bad; cb = cross_bad; lb = lat_bad; ib = inv_bad;
    pulse_start();
    check({tag, ":started"}, {69'd0, busy, done, error, core_reset, s_ready}, 74'b10011);
    for (int i = 0; i < m_used; i++) send(stream[i], mode);
    cnt = 0;
    if (!m_err) begin
      do begin
        @(negedge clk);
        cnt++;
      end while (done !== 1'b1 && cnt < 50);
      check({tag, ":done_latency"}, 74'(cnt), 74'(RC + 1 + (m_pair ? 1 : 0)));
      check({tag, ":done_flags"}, {70'd0, done, core_reset, busy, error}, 74'b1000);
    end else begin
      do begin
        @(negedge clk);
        cnt++;
      end while (error !== 1'b1 && cnt < 50);
      check({tag, ":error_latency"}, 74'(cnt), 74'd1);
      check({tag, ":error_flags"}, {70'd0, s_ready, core_reset, busy, error}, 74'b0101);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check({tag, ":write_count"}, 74'(got_q.size() - got_base), 74'(exp_q.size()));
    nchk = (got_q.size() - got_base < exp_q.size()) ? got_q.size() - got_base : exp_q.size();
    for (int j = 0; j < nchk; j++) check({tag, ":write"}, got_q[got_base + j], exp_q[j]);
    check({tag, ":bus_hold"}, 74'(hold_bad - hb), 74'd0);
    check({tag, ":cross_strobe"}, 74'(cross_bad - cb), 74'd0);
    check({tag, ":strobe_latency"}, 74'(lat_bad - lb), 74'd0);
    check({tag, ":core_reset"}, 74'(inv_bad - ib), 74'd0);
  endtask

  task automatic gen_random(input bit allow_err);
    int nseg;
    int n;
    int a;
    logic [12:0] junk;
    bit tgt;
    stream.delete();
    nseg = $urandom_range(1, 3);
    for (int s = 0; s < nseg; s++) begin
      tgt  = 1'($urandom_range(0, 1));
      junk = 13'($urandom);
      if (allow_err && s == nseg - 1) begin
        n = $urandom_range(1, 3);
        a = $urandom_range(513 - 2 * n, 511);
      end else begin
        n = $urandom_range(0, 3);
        a = $urandom_range(0, 512 - 2 * n);
      end
      stream.push_back({tgt, (s == nseg - 1) ? 1'b1 : 1'b0, junk, 9'(a), 8'(n)});
      for (int k = 0; k < 2 * n; k++) stream.push_back($urandom);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ":flags"},
          {67'd0, s_ready, inst_load_en, data_load_en, busy, done, error, core_reset},
          74'b0000001);
    check({tag, ":inst_bus"}, {1'b0, InstExMemAddress, InstExMemData1, InstExMemData2}, 74'd0);
    check({tag, ":data_bus"}, {1'b0, DataExMemAddress, DataExMemData1, DataExMemData2}, 74'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("reset");

    // Single inst pair.
    stream = {32'h4000_0001, 32'h0010_0393, 32'h0003_8303};
    run_session("single_pair", 0);

    // Two segments, inst then data.
    stream = {32'h0000_0502, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
              32'hC000_0001, 32'h0000_8F00, 32'h0000_00FF};
    run_session("two_segments", 0);

    // Backpressure on the single pair.
    stream = {32'h4000_0001, 32'h0010_0393, 32'h0003_8303};
    run_session("backpressure", 2);

    // Upper boundary: final pair lands at 510/511.
    stream = {32'h4001_FE01, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    run_session("bound_510", 0);

    // One past the boundary aborts.
    stream = {32'h4001_FF01};
    run_session("bound_511", 0);

    // Empty segment before the single pair; also recovers from the error above.
    stream = {32'h0000_0000, 32'h4000_0001, 32'h0010_0393, 32'h0003_8303};
    run_session("empty_segment", 0);

    // Reset after the first payload word.
    base = got_q.size();
    pulse_start();
    send(32'h4000_0001, 0);
    send(32'h0010_0393, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("mid_reset");
    repeat (4) @(posedge clk);
    #1;
    check("mid_reset:no_strobe", 74'(got_q.size() - base), 74'd0);
    stream = {32'h4000_0001, 32'h0010_0393, 32'h0003_8303};
    run_session("after_reset", 0);

    // Randomized sessions.
    for (int r = 0; r < 20; r++) begin
      gen_random($urandom_range(0, 4) == 0);
      run_session("random", int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
